// File: rtl/rca_nibble_seq.sv
// Wide adder sequencer: reuses one external 4-bit ripple-carry adder,
// processing one nibble per cycle, LSB nibble first, with carry chained in a register.
module rca_nibble_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic [3:0]             add_x,
    output logic [3:0]             add_y,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [IW-1:0]   idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                // DONE accepts start exactly like IDLE so results can stream back-to-back
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Compare-based nibble mux keeps index widths exact for every NIBBLES value
                for (int unsigned n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IW'(n)) begin
                        add_x            = a_q[4*n +: 4];
                        add_y            = b_q[4*n +: 4];
                        sum_d[4*n +: 4]  = add_sum;
                    end
                end
                add_cin = carry_q;
                carry_d = add_cout;
                if (idx_q == IW'(NIBBLES - 1)) begin
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_rca_nibble_seq.sv
// Directed bench for rca_nibble_seq: a 4-nibble and a 1-nibble instance,
// each wired to a behavioural 4-bit adder.
module tb_rca_nibble_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start;
    logic [15:0] a, b;
    logic        cin;
    logic        busy, done, cout;
    logic [15:0] sum;
    logic [3:0]  add_x, add_y, add_sum;
    logic        add_cin, add_cout;

    logic        start1;
    logic [3:0]  a1, b1;
    logic        cin1;
    logic        busy1, done1, cout1;
    logic [3:0]  sum1;
    logic [3:0]  add_x1, add_y1, add_sum1;
    logic        add_cin1, add_cout1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum}   = 5'(add_x)  + 5'(add_y)  + 5'(add_cin);
    assign {add_cout1, add_sum1} = 5'(add_x1) + 5'(add_y1) + 5'(add_cin1);

    rca_nibble_seq #(.NIBBLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    rca_nibble_seq #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .add_x(add_x1), .add_y(add_y1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_sum",  32'(sum),  32'h0);
        check("rst_cout", 32'(cout), 32'h0);
        check("rst_addx", 32'(add_x), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'h0);

        // FFFF + 0001: carry ripples through every nibble
        start = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
        tick();
        start = 1'b0;
        check("t1_busy0", 32'(busy), 32'h1);
        check("t1_x0",    32'(add_x), 32'hF);
        check("t1_y0",    32'(add_y), 32'h1);
        check("t1_cin0",  32'(add_cin), 32'h0);
        tick();
        check("t1_busy1", 32'(busy), 32'h1);
        check("t1_y1",    32'(add_y), 32'h0);
        check("t1_cin1",  32'(add_cin), 32'h1);
        tick();
        check("t1_busy2", 32'(busy), 32'h1);
        check("t1_cin2",  32'(add_cin), 32'h1);
        tick();
        check("t1_busy3", 32'(busy), 32'h1);
        check("t1_done3", 32'(done), 32'h0);
        tick();
        check("t1_done",  32'(done), 32'h1);
        check("t1_busyd", 32'(busy), 32'h0);
        check("t1_sum",   32'(sum),  32'h0000);
        check("t1_cout",  32'(cout), 32'h1);
        check("t1_addxd", 32'(add_x), 32'h0);
        tick();
        check("t1_done_off", 32'(done), 32'h0);

        // 1234 + 4321 + 1, with an ignored start (a=AAAA) mid-RUN
        start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1;
        tick();
        start = 1'b0;
        check("t2_x0",   32'(add_x), 32'h4);
        check("t2_cin0", 32'(add_cin), 32'h1);
        tick();
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        check("t2_x1",   32'(add_x), 32'h3);
        check("t2_cin1", 32'(add_cin), 32'h0);
        tick();
        start = 1'b0;
        check("t2_x2",   32'(add_x), 32'h2);
        check("t2_cin2", 32'(add_cin), 32'h0);
        tick();
        check("t2_x3",   32'(add_x), 32'h1);
        check("t2_cin3", 32'(add_cin), 32'h0);
        tick();
        check("t2_done", 32'(done), 32'h1);
        check("t2_sum",  32'(sum),  32'h5556);
        check("t2_cout", 32'(cout), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_no_extra_done", 32'(done), 32'h0);
            check("t2_sum_held",      32'(sum),  32'h5556);
        end

        // back-to-back: 0001+0002, then 8000+8000 accepted in DONE
        start = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0;
        tick();
        a = 16'h8000; b = 16'h8000; cin = 1'b0;
        tick(); tick(); tick(); tick();
        check("t4_done1", 32'(done), 32'h1);
        check("t4_sum1",  32'(sum),  32'h0003);
        check("t4_cout1", 32'(cout), 32'h0);
        tick();
        start = 1'b0;
        check("t4_rerun_busy", 32'(busy), 32'h1);
        check("t4_rerun_done", 32'(done), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_wait_done", 32'(done), 32'h0);
        end
        tick();
        check("t4_done2", 32'(done), 32'h1);
        check("t4_sum2",  32'(sum),  32'h0000);
        check("t4_cout2", 32'(cout), 32'h1);
        tick();

        // reset asserted during the second RUN cycle
        start = 1'b1; a = 16'h1111; b = 16'h1111; cin = 1'b0;
        tick();
        start = 1'b0;
        tick();
        check("t5_busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_done", 32'(done), 32'h0);
        check("t5_sum",  32'(sum),  32'h0);
        check("t5_cout", 32'(cout), 32'h0);
        check("t5_addx", 32'(add_x), 32'h0);
        check("t5_addy", 32'(add_y), 32'h0);
        check("t5_acin", 32'(add_cin), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_no_done", 32'(done), 32'h0);
        end
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        check("t5_done_new", 32'(done), 32'h1);
        check("t5_sum_new",  32'(sum),  32'hFFFF);
        check("t5_cout_new", 32'(cout), 32'h1);
        tick();

        // NIBBLES=1: F + F + 1
        start1 = 1'b1; a1 = 4'hF; b1 = 4'hF; cin1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("n1_busy", 32'(busy1), 32'h1);
        check("n1_x",    32'(add_x1), 32'hF);
        check("n1_cin",  32'(add_cin1), 32'h1);
        tick();
        check("n1_done", 32'(done1), 32'h1);
        check("n1_sum",  32'(sum1),  32'hF);
        check("n1_cout", 32'(cout1), 32'h1);
        tick();
        check("n1_done_off", 32'(done1), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rca_nibble_seq.md
Name: rca_nibble_seq

Overview:
Sequencer that performs a wide addition by reusing one external 4-bit ripple-carry adder over several clock cycles, one nibble per cycle, least significant nibble first. It latches the operands on a start request and drives the adder's x/y/carry-in inputs. It captures the adder's sum/carry-out into a result register and chains the carry between cycles. It reports completion with a one-cycle done pulse. It sits between a requesting unit and the shared 4-bit adder instance.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on a clk edge when state is IDLE or DONE
a  input  W  operand A; sampled with start
b  input  W  operand B; sampled with start
cin  input  1  initial carry-in; sampled with start
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse; result valid
sum  output  W  result; held until the next accepted start
cout  output  1  final carry-out; held with sum
add_x  output  4  to adder x input
add_y  output  4  to adder y input
add_cin  output  1  to adder carry input
add_sum  input  4  from adder sum output (combinational, same cycle)
add_cout  input  1  from adder carry output

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy=0, done=0, sum=0, cout=0; internal operand regs, carry reg and index=0; add_x/add_y/add_cin=0. Reset asserted mid-RUN aborts the operation with no done pulse.
- States:
  - IDLE: start=1 -> latch a, b; carry_reg<=cin; idx<=0; go to RUN. Otherwise stay.
  - RUN: add_x=a_reg[4*idx+:4], add_y=b_reg[4*idx+:4], add_cin=carry_reg.
    - Each edge: sum[4*idx+:4]<=add_sum; carry_reg<=add_cout; idx<=idx+1.
    - At idx==NIBBLES-1: also cout<=add_cout; go to DONE.
  - DONE: done=1 for exactly this cycle. start=1 is accepted as in IDLE (back-to-back), going to RUN. Otherwise go to IDLE.
- start in RUN is ignored: no re-latch, no effect on the result.
- add_x/add_y/add_cin = 0 in IDLE and DONE.
- busy=1 only in RUN; busy and done are never high together.
- Latency: start is sampled at edge E0. RUN spans NIBBLES cycles. done is high in the cycle after edge E0+NIBBLES. Throughput is one result per NIBBLES+1 cycles.
- Result update rules:
  - sum nibbles update progressively during RUN; sum is defined valid only when done=1 and thereafter until the next accepted start.
  - Upper sum nibbles are not cleared on start; each is overwritten in turn.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(W+1); no overflow flag.
- idx width = max(1, clog2(NIBBLES)); idx never exceeds NIBBLES-1.
- NIBBLES=1: RUN lasts one cycle; the single nibble result and cout are captured on that edge.

Test Plan:
- NIBBLES=4, a=0xFFFF, b=0x0001, cin=0, start one cycle -> busy high 4 cycles; done pulse at E0+4; sum=0x0000, cout=1; the carry must propagate through all nibbles.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; add_x sequence 4,3,2,1 and add_cin sequence 1,0,0,0 across the RUN cycles.
- Start again during RUN with a=0xAAAA -> ignored; first result is unchanged; no extra done pulse.
- Hold start=1 across DONE with new operands 0x8000+0x8000 cin0 -> immediate re-entry to RUN; second done 5 cycles after the first; sum=0x0000, cout=1.
- Assert rst_n=0 during the 2nd RUN cycle -> busy, done, sum, cout and add_* go to 0 immediately (asynchronously); no done after release; a new start then completes normally.
- NIBBLES=1, a=0xF, b=0xF, cin=1 -> done at E0+1; sum=0xF, cout=1.
